// File: rtl/mips_defs_pkg.sv
// Shared MIPS pipeline definitions: opcode/funct encodings, ALU operation codes
// and the Tnew values each stage reports to the hazard unit.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_NOR  = 5'd5,
    ALU_SLT  = 5'd6,
    ALU_SLTU = 5'd7,
    ALU_SLL  = 5'd8,
    ALU_SRL  = 5'd9,
    ALU_SRA  = 5'd10,
    ALU_LUI  = 5'd11
  } aluop_t;

  localparam logic [3:0] TNEW_E = 4'd2;
  localparam logic [3:0] TNEW_M = 4'd1;
  localparam logic [3:0] TNEW_W = 4'd0;

endpackage

// File: rtl/wb_stage_unit_main_ctrl.sv
// Main control decoder: turns one instruction word into the full control set.
// Shared by every pipeline stage, so it carries no stage-specific logic.
module main_ctrl
  import mips_defs::*;
(
  input  logic [31:0] ir,
  output logic        regDst,
  output logic        reg31,
  output logic        siExt,
  output logic        shift2,
  output logic        regWrite,
  output logic        ALUSrc1,
  output logic        ALUSrc2,
  output logic        regIn,
  output logic        memWrite,
  output logic        branch,
  output logic        j,
  output logic        jr,
  output logic        jl,
  output logic [4:0]  ALUOP
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rtField;
  logic [4:0] rdField;
  logic       writesRd;
  logic       writesRt;
  logic       unusedFields;

  assign op           = ir[31:26];
  assign fn           = ir[5:0];
  assign rtField      = ir[20:16];
  assign rdField      = ir[15:11];
  assign unusedFields = ^{ir[25:21], ir[10:6]};

  // The all-zero word (sll $0,$0,0) is the pipeline bubble, so it decodes to nothing
  always_comb begin
    reg31    = 1'b0;
    siExt    = 1'b0;
    shift2   = 1'b0;
    ALUSrc1  = 1'b0;
    ALUSrc2  = 1'b0;
    regIn    = 1'b0;
    memWrite = 1'b0;
    branch   = 1'b0;
    j        = 1'b0;
    jr       = 1'b0;
    jl       = 1'b0;
    ALUOP    = ALU_ADD;
    writesRd = 1'b0;
    writesRt = 1'b0;
    if (ir != '0) begin
      case (op)
        OP_RTYPE: begin
          case (fn)
            FN_ADDU: begin ALUOP = ALU_ADD;  writesRd = 1'b1; end
            FN_SUBU: begin ALUOP = ALU_SUB;  writesRd = 1'b1; end
            FN_AND:  begin ALUOP = ALU_AND;  writesRd = 1'b1; end
            FN_OR:   begin ALUOP = ALU_OR;   writesRd = 1'b1; end
            FN_XOR:  begin ALUOP = ALU_XOR;  writesRd = 1'b1; end
            FN_NOR:  begin ALUOP = ALU_NOR;  writesRd = 1'b1; end
            FN_SLT:  begin ALUOP = ALU_SLT;  writesRd = 1'b1; end
            FN_SLTU: begin ALUOP = ALU_SLTU; writesRd = 1'b1; end
            FN_SLL:  begin ALUOP = ALU_SLL; writesRd = 1'b1; shift2 = 1'b1; ALUSrc1 = 1'b1; end
            FN_SRL:  begin ALUOP = ALU_SRL; writesRd = 1'b1; shift2 = 1'b1; ALUSrc1 = 1'b1; end
            FN_SRA:  begin ALUOP = ALU_SRA; writesRd = 1'b1; shift2 = 1'b1; ALUSrc1 = 1'b1; end
            FN_JR:   jr = 1'b1;
            FN_JALR: begin jr = 1'b1; jl = 1'b1; writesRd = 1'b1; end
            default: ;
          endcase
        end
        OP_ADDIU: begin ALUOP = ALU_ADD;  siExt = 1'b1; ALUSrc2 = 1'b1; writesRt = 1'b1; end
        OP_SLTI:  begin ALUOP = ALU_SLT;  siExt = 1'b1; ALUSrc2 = 1'b1; writesRt = 1'b1; end
        OP_SLTIU: begin ALUOP = ALU_SLTU; siExt = 1'b1; ALUSrc2 = 1'b1; writesRt = 1'b1; end
        OP_ANDI:  begin ALUOP = ALU_AND;  ALUSrc2 = 1'b1; writesRt = 1'b1; end
        OP_ORI:   begin ALUOP = ALU_OR;   ALUSrc2 = 1'b1; writesRt = 1'b1; end
        OP_XORI:  begin ALUOP = ALU_XOR;  ALUSrc2 = 1'b1; writesRt = 1'b1; end
        OP_LUI:   begin ALUOP = ALU_LUI;  ALUSrc2 = 1'b1; writesRt = 1'b1; end
        OP_LW:    begin siExt = 1'b1; ALUSrc2 = 1'b1; regIn = 1'b1; writesRt = 1'b1; end
        OP_SW:    begin siExt = 1'b1; ALUSrc2 = 1'b1; memWrite = 1'b1; end
        OP_BEQ, OP_BNE: begin ALUOP = ALU_SUB; siExt = 1'b1; branch = 1'b1; end
        OP_J:     j = 1'b1;
        OP_JAL:   begin j = 1'b1; jl = 1'b1; reg31 = 1'b1; end
        default: ;
      endcase
    end
    regDst   = writesRd;
    regWrite = (writesRd && rdField != 5'd0) || (writesRt && rtField != 5'd0) || reg31;
  end

endmodule

// File: rtl/wb_stage_unit.sv
// Writeback stage: M->W pipeline register, instruction decode and the GRF write port.
// Anything not latched here is combinational off the registered values.
module wb_stage_unit
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] IR_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] PC8_in,
  input  logic [31:0] DR_in,
  input  logic [31:0] AO_in,
  input  logic        BranchOP_in,
  output logic [31:0] PCO,
  output logic [31:0] PC8O,
  output logic [31:0] DRO,
  output logic [31:0] AOO,
  output logic        BranchOPO,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [3:0]  tnew,
  output logic [4:0]  writereg,
  output logic [31:0] writedata,
  output logic        regDst,
  output logic        reg31,
  output logic        siExt,
  output logic        shift2,
  output logic        regWrite,
  output logic        ALUSrc1,
  output logic        ALUSrc2,
  output logic        regIn,
  output logic        memWrite,
  output logic        branch,
  output logic        j,
  output logic        jr,
  output logic        jl,
  output logic [4:0]  ALUOP
);

  logic [31:0] irReg;

  // Reset and stall both leave an all-zero bubble, which decodes as a NOP
  always_ff @(posedge clk) begin
    if (!reset || stall) begin
      irReg     <= '0;
      PCO       <= '0;
      PC8O      <= '0;
      DRO       <= '0;
      AOO       <= '0;
      BranchOPO <= 1'b0;
    end else begin
      irReg     <= IR_in;
      PCO       <= PC_in;
      PC8O      <= PC8_in;
      DRO       <= DR_in;
      AOO       <= AO_in;
      BranchOPO <= BranchOP_in;
    end
  end

  main_ctrl ctrl (
    .ir       (irReg),
    .regDst   (regDst),
    .reg31    (reg31),
    .siExt    (siExt),
    .shift2   (shift2),
    .regWrite (regWrite),
    .ALUSrc1  (ALUSrc1),
    .ALUSrc2  (ALUSrc2),
    .regIn    (regIn),
    .memWrite (memWrite),
    .branch   (branch),
    .j        (j),
    .jr       (jr),
    .jl       (jl),
    .ALUOP    (ALUOP)
  );

  assign rt   = irReg[20:16];
  assign rd   = irReg[15:11];
  assign tnew = TNEW_W;

  always_comb begin
    writereg = 5'd0;
    if (regWrite) begin
      if (reg31)       writereg = 5'd31;
      else if (regDst) writereg = rd;
      else             writereg = rt;
    end
  end

  always_comb begin
    if (regIn)   writedata = DRO;
    else if (jl) writedata = PC8O;
    else         writedata = AOO;
  end

endmodule

// File: tb/tb_wb_stage_unit.sv
// Self-checking bench for wb_stage_unit: directed instruction scenarios plus
// randomized traffic compared against a mnemonic-level behavioural model.
module tb_wb_stage_unit;

  typedef struct packed {
    logic       regDst, reg31, siExt, shift2, regWrite, ALUSrc1, ALUSrc2;
    logic       regIn, memWrite, branch, j, jr, jl;
    logic [4:0] aluop;
  } ctrl_t;

  logic        clk = 1'b0;
  logic        reset, stall, BranchOP_in;
  logic [31:0] IR_in, PC_in, PC8_in, DR_in, AO_in;
  logic [31:0] PCO, PC8O, DRO, AOO, writedata;
  logic        BranchOPO;
  logic [4:0]  rt, rd, writereg, ALUOP;
  logic [3:0]  tnew;
  logic        regDst, reg31, siExt, shift2, regWrite, ALUSrc1, ALUSrc2;
  logic        regIn, memWrite, branch, j, jr, jl;
  ctrl_t       dutCtrl;

  int checks = 0;
  int failures = 0;

  logic [31:0] expIr, expPc, expPc8, expDr, expAo;
  logic        expBop;

  always #5 clk = ~clk;

  assign dutCtrl = '{regDst, reg31, siExt, shift2, regWrite, ALUSrc1, ALUSrc2,
                     regIn, memWrite, branch, j, jr, jl, ALUOP};

  wb_stage_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .IR_in(IR_in), .PC_in(PC_in), .PC8_in(PC8_in), .DR_in(DR_in), .AO_in(AO_in),
    .BranchOP_in(BranchOP_in),
    .PCO(PCO), .PC8O(PC8O), .DRO(DRO), .AOO(AOO), .BranchOPO(BranchOPO),
    .rt(rt), .rd(rd), .tnew(tnew), .writereg(writereg), .writedata(writedata),
    .regDst(regDst), .reg31(reg31), .siExt(siExt), .shift2(shift2),
    .regWrite(regWrite), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .regIn(regIn),
    .memWrite(memWrite), .branch(branch), .j(j), .jr(jr), .jl(jl), .ALUOP(ALUOP)
  );

  // Name the instruction from its fields; unknown encodings and the zero word give ""
  function automatic string mnemonic(input logic [31:0] ir);
    string n = "";
    if (ir != 32'h0) begin
      if (ir[31:26] == 6'h00) begin
        case (ir[5:0])
          6'h21: n = "addu";  6'h23: n = "subu";  6'h24: n = "and";  6'h25: n = "or";
          6'h26: n = "xor";   6'h27: n = "nor";   6'h2a: n = "slt";  6'h2b: n = "sltu";
          6'h00: n = "sll";   6'h02: n = "srl";   6'h03: n = "sra";  6'h08: n = "jr";
          6'h09: n = "jalr";
          default: n = "";
        endcase
      end else begin
        case (ir[31:26])
          6'h09: n = "addiu"; 6'h0c: n = "andi";  6'h0d: n = "ori";  6'h0e: n = "xori";
          6'h0f: n = "lui";   6'h0a: n = "slti";  6'h0b: n = "sltiu"; 6'h23: n = "lw";
          6'h2b: n = "sw";    6'h04: n = "beq";   6'h05: n = "bne";  6'h02: n = "j";
          6'h03: n = "jal";
          default: n = "";
        endcase
      end
    end
    return n;
  endfunction

  function automatic ctrl_t modelCtrl(input logic [31:0] ir, output logic [4:0] dest);
    ctrl_t c = '0;
    string n = mnemonic(ir);
    logic isShift, isImmAlu, writesRd;
    case (n)
      "subu", "beq", "bne": c.aluop = 5'd1;
      "and", "andi":        c.aluop = 5'd2;
      "or", "ori":          c.aluop = 5'd3;
      "xor", "xori":        c.aluop = 5'd4;
      "nor":                c.aluop = 5'd5;
      "slt", "slti":        c.aluop = 5'd6;
      "sltu", "sltiu":      c.aluop = 5'd7;
      "sll":                c.aluop = 5'd8;
      "srl":                c.aluop = 5'd9;
      "sra":                c.aluop = 5'd10;
      "lui":                c.aluop = 5'd11;
      default:              c.aluop = 5'd0;
    endcase
    isShift  = (n == "sll") || (n == "srl") || (n == "sra");
    isImmAlu = (n == "addiu") || (n == "andi") || (n == "ori") || (n == "xori") ||
               (n == "lui") || (n == "slti") || (n == "sltiu");
    writesRd = (n != "") && (ir[31:26] == 6'h00) && (n != "jr");
    c.regDst   = writesRd;
    c.reg31    = (n == "jal");
    c.siExt    = (n == "addiu") || (n == "slti") || (n == "sltiu") || (n == "lw") ||
                 (n == "sw") || (n == "beq") || (n == "bne");
    c.shift2   = isShift;
    c.ALUSrc1  = isShift;
    c.ALUSrc2  = isImmAlu || (n == "lw") || (n == "sw");
    c.regIn    = (n == "lw");
    c.memWrite = (n == "sw");
    c.branch   = (n == "beq") || (n == "bne");
    c.j        = (n == "j") || (n == "jal");
    c.jr       = (n == "jr") || (n == "jalr");
    c.jl       = (n == "jal") || (n == "jalr");
    if (writesRd)                      dest = ir[15:11];
    else if (isImmAlu || n == "lw")    dest = ir[20:16];
    else if (n == "jal")               dest = 5'd31;
    else                               dest = 5'd0;
    c.regWrite = (dest != 5'd0);
    return c;
  endfunction

  // Drive one set of inputs, track what the W register should hold, and clock it in
  task automatic applyStimulus(input logic [31:0] ir, input logic [31:0] pc,
                               input logic [31:0] pc8, input logic [31:0] dr,
                               input logic [31:0] ao, input logic bop,
                               input logic rst, input logic stl);
    IR_in = ir; PC_in = pc; PC8_in = pc8; DR_in = dr; AO_in = ao; BranchOP_in = bop;
    reset = rst; stall = stl;
    if (!rst || stl) begin
      expIr = '0; expPc = '0; expPc8 = '0; expDr = '0; expAo = '0; expBop = 1'b0;
    end else begin
      expIr = ir; expPc = pc; expPc8 = pc8; expDr = dr; expAo = ao; expBop = bop;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    applyStimulus(32'h00221821, 32'h1234, 32'h123c, 32'hffff_ffff, 32'h5555_aaaa, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({PCO, PC8O, DRO, AOO, BranchOPO} !== 129'h0) begin
      failures++;
      $display("[TB] FAIL reset_latch: got %h %h %h %h %b, want all 0", PCO, PC8O, DRO, AOO, BranchOPO);
    end
    checks++;
    if ({writereg, regWrite, writedata, tnew} !== 42'h0) begin
      failures++;
      $display("[TB] FAIL reset_wb: writereg=%0d regWrite=%b writedata=%h tnew=%0d, want 0",
               writereg, regWrite, writedata, tnew);
    end
    checks++;
    if (dutCtrl !== ctrl_t'(0)) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %h want 0", dutCtrl);
    end
  endtask

  task automatic test_addu;
    applyStimulus(32'h00221821, 32'h3000, 32'h3008, 32'h0bad_0bad, 32'h0000_0005, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({writereg, writedata} !== {5'd3, 32'd5}) begin
      failures++;
      $display("[TB] FAIL addu_wb: writereg=%0d writedata=%h want 3 / 00000005", writereg, writedata);
    end
    checks++;
    if ({regDst, regWrite, ALUOP, rd, rt} !== {1'b1, 1'b1, 5'd0, 5'd3, 5'd2}) begin
      failures++;
      $display("[TB] FAIL addu_ctrl: regDst=%b regWrite=%b ALUOP=%0d rd=%0d rt=%0d want 1 1 0 3 2",
               regDst, regWrite, ALUOP, rd, rt);
    end
  endtask

  task automatic test_lw;
    applyStimulus(32'h8FA40008, 32'h3004, 32'h300c, 32'hDEADBEEF, 32'h0000_1008, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({writereg, writedata} !== {5'd4, 32'hDEADBEEF}) begin
      failures++;
      $display("[TB] FAIL lw_wb: writereg=%0d writedata=%h want 4 / deadbeef", writereg, writedata);
    end
    checks++;
    if ({regIn, siExt, ALUSrc2, regWrite, regDst} !== 5'b11110) begin
      failures++;
      $display("[TB] FAIL lw_ctrl: regIn=%b siExt=%b ALUSrc2=%b regWrite=%b regDst=%b want 1 1 1 1 0",
               regIn, siExt, ALUSrc2, regWrite, regDst);
    end
  endtask

  task automatic test_jal;
    applyStimulus(32'h0C000100, 32'h3000, 32'h00003008, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({writereg, writedata} !== {5'd31, 32'h00003008}) begin
      failures++;
      $display("[TB] FAIL jal_wb: writereg=%0d writedata=%h want 31 / 00003008", writereg, writedata);
    end
    checks++;
    if ({reg31, jl, j, jr, regWrite} !== 5'b11101) begin
      failures++;
      $display("[TB] FAIL jal_ctrl: reg31=%b jl=%b j=%b jr=%b regWrite=%b want 1 1 1 0 1",
               reg31, jl, j, jr, regWrite);
    end
  endtask

  task automatic test_sw_beq;
    applyStimulus(32'hAC040000, 32'h3010, 32'h3018, 32'h0, 32'h0000_0040, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({writereg, regWrite, memWrite} !== {5'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL sw: writereg=%0d regWrite=%b memWrite=%b want 0 0 1", writereg, regWrite, memWrite);
    end
    applyStimulus(32'h10220003, 32'h3014, 32'h301c, 32'h0, 32'hffff_fffe, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({writereg, regWrite, branch, ALUOP, BranchOPO} !== {5'd0, 1'b0, 1'b1, 5'd1, 1'b1}) begin
      failures++;
      $display("[TB] FAIL beq: writereg=%0d regWrite=%b branch=%b ALUOP=%0d BranchOPO=%b want 0 0 1 1 1",
               writereg, regWrite, branch, ALUOP, BranchOPO);
    end
  endtask

  task automatic test_stall;
    applyStimulus(32'h00221821, 32'h3020, 32'h3028, 32'h7777_7777, 32'h0000_0005, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({rt, rd, writereg, writedata, PCO, BranchOPO} !== 80'h0 || dutCtrl !== ctrl_t'(0)) begin
      failures++;
      $display("[TB] FAIL stall_bubble: rt=%0d rd=%0d writereg=%0d writedata=%h PCO=%h ctrl=%h want all 0",
               rt, rd, writereg, writedata, PCO, dutCtrl);
    end
    applyStimulus(32'h00221821, 32'h3020, 32'h3028, 32'h7777_7777, 32'h0000_0005, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({writereg, writedata, PCO} !== 69'h0) begin
      failures++;
      $display("[TB] FAIL reset_and_stall: writereg=%0d writedata=%h PCO=%h want 0", writereg, writedata, PCO);
    end
  endtask

  task automatic test_write_zero;
    applyStimulus(32'h34000001, 32'h3030, 32'h3038, 32'h0, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({writereg, regWrite, ALUSrc2, ALUOP} !== {5'd0, 1'b0, 1'b1, 5'd3}) begin
      failures++;
      $display("[TB] FAIL ori_zero: writereg=%0d regWrite=%b ALUSrc2=%b ALUOP=%0d want 0 0 1 3",
               writereg, regWrite, ALUSrc2, ALUOP);
    end
  endtask

  // Random instruction mix over every supported encoding plus two unsupported ones
  function automatic logic [31:0] randomInstr();
    logic [5:0] ops [0:12]  = '{6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h0a, 6'h0b,
                                6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [5:0] fns [0:13]  = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a,
                                6'h2b, 6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20};
    logic [4:0] r1, r2, r3;
    logic [31:0] w = $urandom;
    r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    r2 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    r3 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 2, 3: w = {6'h00, r1, r2, r3, w[10:6], fns[$urandom_range(0, 13)]};
      4:          w = {6'h20, r1, r2, w[15:0]};
      5:          w = 32'h0;
      default:    w = {ops[$urandom_range(0, 12)], r1, r2, w[15:0]};
    endcase
    return w;
  endfunction

  task automatic test_random;
    ctrl_t       expCtrl;
    logic [4:0]  expDest;
    logic [31:0] expData;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(randomInstr(), $urandom, $urandom, $urandom, $urandom, 1'($urandom),
                    ($urandom_range(0, 19) != 0), ($urandom_range(0, 9) == 0));
      expCtrl = modelCtrl(expIr, expDest);
      expData = expCtrl.regIn ? expDr : (expCtrl.jl ? expPc8 : expAo);
      checks++;
      if ({PCO, PC8O, DRO, AOO, BranchOPO} !== {expPc, expPc8, expDr, expAo, expBop}) begin
        failures++;
        $display("[TB] FAIL rand_latch[%0d]: got %h %h %h %h %b want %h %h %h %h %b", i,
                 PCO, PC8O, DRO, AOO, BranchOPO, expPc, expPc8, expDr, expAo, expBop);
      end
      checks++;
      if (dutCtrl !== expCtrl) begin
        failures++;
        $display("[TB] FAIL rand_ctrl[%0d]: ir=%h got %h want %h", i, expIr, dutCtrl, expCtrl);
      end
      checks++;
      if ({writereg, writedata, rt, rd, tnew} !== {expDest, expData, expIr[20:16], expIr[15:11], 4'd0}) begin
        failures++;
        $display("[TB] FAIL rand_wb[%0d]: ir=%h writereg=%0d writedata=%h rt=%0d rd=%0d tnew=%0d want %0d %h %0d %0d 0",
                 i, expIr, writereg, writedata, rt, rd, tnew, expDest, expData, expIr[20:16], expIr[15:11]);
      end
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; BranchOP_in = 1'b0;
    IR_in = '0; PC_in = '0; PC8_in = '0; DR_in = '0; AO_in = '0;
    #2;
    test_reset();
    test_addu();
    test_lw();
    test_jal();
    test_sw_beq();
    test_stall();
    test_write_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage_unit.md
Name: wb_stage_unit

Overview:
- Writeback (W) stage of the 5-stage MIPS pipeline.
- Holds the M→W pipeline register (IR, PC, PC8, DR, AO, BranchOP) and decodes the latched instruction.
- Produces the register-file write port (writereg/writedata), the W-stage Tnew for the hazard unit, and the full main-control signal set for the W instruction.

Parameters:
- None.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 clears the pipeline register)
- stall  in  1  1 = load a bubble into the W register this edge
- IR_in  in  32  instruction from M
- PC_in  in  32  instruction PC from M
- PC8_in  in  32  PC+8 from M
- DR_in  in  32  memory read data from M
- AO_in  in  32  ALU result from M
- BranchOP_in  in  1  branch-taken flag from M
- PCO, PC8O, DRO, AOO  out  32 each  latched values
- BranchOPO  out  1  latched BranchOP
- rt, rd  out  5 each  IR[20:16], IR[15:11]
- tnew  out  4  always 0 (result ready in W)
- writereg  out  5  GRF destination; 0 when there is no write
- writedata  out  32  GRF write data
- regDst, reg31, siExt, shift2, regWrite, ALUSrc1, ALUSrc2, regIn, memWrite, branch, j, jr, jl  out  1 each  control
- ALUOP  out  5  ALU operation code

Behaviour:
- Register update on posedge clk:
  - reset==0: all registers cleared to 0. IR=0 is sll $0 and acts as a NOP.
  - else if stall==1: all registers loaded with 0 (bubble).
  - else: all registers loaded from the *_in inputs.
- All other outputs are purely combinational from the registered values. Latency is 1 cycle.
- Supported instructions (others decode to all-zero controls):
  - R-type: addu, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, jr, jalr.
  - I-type: addiu, andi, ori, xori, lui, slti, sltiu, lw, sw, beq, bne.
  - J-type: j, jal.
- ALUOP encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, SRA=10, LUI=11.
  - Arithmetic, load/store and jumps use ADD.
  - beq/bne use SUB.
- Control signal definitions:
  - regDst=1: R-type writes rd.
  - reg31=1: jal.
  - siExt=1: addiu, slti, sltiu, lw, sw, beq, bne. All other immediates are zero-extended.
  - shift2=1 and ALUSrc1=1: sll/srl/sra (ALU A operand = shamt).
  - ALUSrc2=1: I-type ALU ops, lw, sw.
  - regIn=1: lw.
  - memWrite=1: sw.
  - branch=1: beq/bne.
  - j=1: j/jal.
  - jr=1: jr/jalr.
  - jl=1: jal/jalr.
- regWrite=1 for every writing instruction except when the destination is $0.
- writereg:
  - 31 for jal.
  - rd for R-type writers, including jalr.
  - rt for I-type writers and lw.
  - 0 otherwise.
- writedata:
  - DRO when regIn=1.
  - PC8O when jl=1.
  - AOO otherwise.
- tnew is constantly 4'd0.
- BranchOPO is a pure latch and does not gate any control.
- Simultaneous reset==0 and stall==1: reset wins; the result is identical (all zero).

Decomposition:
- Shared package mips_defs holds:
  - opcode/funct localparams;
  - ALUOP codes;
  - Tnew constants.
- One natural sub-module, main_ctrl: a combinational decoder from IR to all control signals and ALUOP. It is reused by the D/E/M stages.
- The writeback muxes and pipeline register stay in wb_stage_unit.

Test Plan:
- Reset: reset=0 with arbitrary inputs, one edge → all latched outputs 0; writereg=0, regWrite=0, writedata=0, tnew=0.
- addu $3,$1,$2 (IR=0x00221821), AO_in=0x0000_0005 → after edge writereg=3, writedata=5, regDst=1, regWrite=1, ALUOP=0.
- lw $4,8($29) (IR=0x8FA40008), DR_in=0xDEADBEEF → writereg=4, writedata=0xDEADBEEF, regIn=1, siExt=1, ALUSrc2=1.
- jal (IR=0x0C000100), PC8_in=0x00003008 → writereg=31, writedata=0x00003008, reg31=1, jl=1, j=1.
- sw (IR=0xAC040000) and beq (IR=0x10220003) → writereg=0, regWrite=0; memWrite=1 for sw; branch=1 and ALUOP=1 for beq; BranchOPO follows BranchOP_in.
- stall=1 while valid addu is presented → bubble latched: IR=0, writereg=0, all controls 0. ori $0,$0,1 (IR=0x34000001) → writereg=0, regWrite=0.
